// File: rtl/nbit_alu_if.sv
// nbit_alu_if -- operand/result bundle for the registered N-bit ALU.
// Optional flag signals (zero, overflow) exist only when NBIT_ALU_FLAGS_EN
// is defined; the default build carries Y and carry_out only.
interface nbit_alu_if #(
  parameter int N = 4
);
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [2:0]   mode;
  logic [N-1:0] Y;
  logic         carry_out;
`ifdef NBIT_ALU_FLAGS_EN
  logic         zero;
  logic         overflow;

  modport master (output A, output B, output mode,
                  input Y, input carry_out, input zero, input overflow);
  modport slave  (input A, input B, input mode,
                  output Y, output carry_out, output zero, output overflow);
`else
  modport master (output A, output B, output mode,
                  input Y, input carry_out);
  modport slave  (input A, input B, input mode,
                  output Y, output carry_out);
`endif
endinterface

// File: rtl/nbit_alu.sv
// nbit_alu -- N-bit ALU with a one-cycle registered result.
// Operands and mode are captured every rising edge; Y/carry_out (and the
// optional zero/overflow flags, enabled by defining NBIT_ALU_FLAGS_EN)
// reflect that operation after the edge. rst is synchronous, active-high,
// and wins over the operation sampled on the same edge.
module nbit_alu #(
  parameter int N = 4
) (
  input  logic      clk,
  input  logic      rst,
  nbit_alu_if.slave bus
);

  localparam logic [2:0] MODE_ADD = 3'b000;
  localparam logic [2:0] MODE_SUB = 3'b001;
  localparam logic [2:0] MODE_AND = 3'b010;
  localparam logic [2:0] MODE_OR  = 3'b011;
  localparam logic [2:0] MODE_XOR = 3'b100;
  localparam logic [2:0] MODE_NOT = 3'b101;
  localparam logic [2:0] MODE_INC = 3'b110;
  localparam logic [2:0] MODE_DEC = 3'b111;

  localparam logic [N:0]   ONE_EXT = {{N{1'b0}}, 1'b1};
  localparam logic [N-1:0] Y_ZERO  = {N{1'b0}};

  // Zero-extended operands: bit N of each arithmetic result is the carry
  // (for additions) or the borrow (for subtractions).
  logic [N:0] a_ext;
  logic [N:0] b_ext;
  logic [N:0] sum_ext;
  logic [N:0] diff_ext;
  logic [N:0] inc_ext;
  logic [N:0] dec_ext;

  logic [N-1:0] y_d;
  logic [N-1:0] y_q;
  logic         carry_d;
  logic         carry_q;

  assign a_ext    = {1'b0, bus.A};
  assign b_ext    = {1'b0, bus.B};
  assign sum_ext  = a_ext + b_ext;
  assign diff_ext = a_ext - b_ext;
  assign inc_ext  = a_ext + ONE_EXT;
  assign dec_ext  = a_ext - ONE_EXT;

  // Select the result and carry/borrow for the requested operation.
  always_comb begin
    y_d     = Y_ZERO;
    carry_d = 1'b0;
    case (bus.mode)
      MODE_ADD: begin
        y_d     = sum_ext[N-1:0];
        carry_d = sum_ext[N];
      end
      MODE_SUB: begin
        y_d     = diff_ext[N-1:0];
        carry_d = diff_ext[N];
      end
      MODE_AND: begin
        y_d     = bus.A & bus.B;
        carry_d = 1'b0;
      end
      MODE_OR: begin
        y_d     = bus.A | bus.B;
        carry_d = 1'b0;
      end
      MODE_XOR: begin
        y_d     = bus.A ^ bus.B;
        carry_d = 1'b0;
      end
      MODE_NOT: begin
        y_d     = ~bus.A;
        carry_d = 1'b0;
      end
      MODE_INC: begin
        y_d     = inc_ext[N-1:0];
        carry_d = inc_ext[N];
      end
      MODE_DEC: begin
        y_d     = dec_ext[N-1:0];
        carry_d = dec_ext[N];
      end
      // Unknown mode (X/Z) produces a benign all-zero result.
      default: begin
        y_d     = Y_ZERO;
        carry_d = 1'b0;
      end
    endcase
  end

  // Result register: reset clears, otherwise capture this cycle's operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q     <= Y_ZERO;
      carry_q <= 1'b0;
    end else begin
      y_q     <= y_d;
      carry_q <= carry_d;
    end
  end

  assign bus.Y         = y_q;
  assign bus.carry_out = carry_q;

`ifdef NBIT_ALU_FLAGS_EN
  logic a_sign;
  logic b_sign;
  logic zero_d;
  logic zero_q;
  logic overflow_d;
  logic overflow_q;

  assign a_sign = bus.A[N-1];
  assign b_sign = bus.B[N-1];
  assign zero_d = (y_d == Y_ZERO);

  // Signed overflow: the result sign contradicts what the operand signs allow.
  always_comb begin
    overflow_d = 1'b0;
    case (bus.mode)
      MODE_ADD: overflow_d = (a_sign == b_sign) && (sum_ext[N-1] != a_sign);
      MODE_SUB: overflow_d = (a_sign != b_sign) && (diff_ext[N-1] != a_sign);
      MODE_INC: overflow_d = !a_sign && inc_ext[N-1];
      MODE_DEC: overflow_d = a_sign && !dec_ext[N-1];
      MODE_AND: overflow_d = 1'b0;
      MODE_OR:  overflow_d = 1'b0;
      MODE_XOR: overflow_d = 1'b0;
      MODE_NOT: overflow_d = 1'b0;
      default:  overflow_d = 1'b0;
    endcase
  end

  // Flag register, aligned with the result register; reset reports Y == 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q     <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      zero_q     <= zero_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.zero     = zero_q;
  assign bus.overflow = overflow_q;
`endif

endmodule

// File: tb/tb_nbit_alu.sv
// tb_nbit_alu -- self-checking bench for nbit_alu (N=4). Expected values
// come from spec constants and an integer-arithmetic reference model.
// Flag checks are included when NBIT_ALU_FLAGS_EN is defined.
module tb_nbit_alu;

  localparam int N    = 4;
  localparam int MODV = 1 << N;
  localparam int HALF = 1 << (N - 1);

  logic clk;
  logic rst;
  int   total;
  int   bad;

  nbit_alu_if #(.N(N)) alu_if ();

  nbit_alu #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (alu_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [2:0]   m;
    logic [N-1:0] y;
    logic         c;
    logic         z;
    logic         o;
  } vec_t;

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic void ref_op(input int a, input int b, input logic [2:0] m,
                                 output logic [N-1:0] y, output logic c,
                                 output logic z, output logic o);
    int sa, sb, sr, r, yi;
    sa = (a >= HALF) ? a - MODV : a;
    sb = (b >= HALF) ? b - MODV : b;
    r = 0; sr = 0; c = 1'b0; o = 1'b0;
    case (m)
      3'd0: begin r = a + b; c = (r >= MODV); sr = sa + sb; o = (sr < -HALF) || (sr >= HALF); end
      3'd1: begin r = a - b; c = (a < b);     sr = sa - sb; o = (sr < -HALF) || (sr >= HALF); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = (MODV - 1) - a;
      3'd6: begin r = a + 1; c = (a == MODV - 1); sr = sa + 1; o = (sr >= HALF); end
      3'd7: begin r = a - 1; c = (a == 0);        sr = sa - 1; o = (sr < -HALF); end
      default: r = 0;
    endcase
    yi = ((r % MODV) + MODV) % MODV;
    y  = yi[N-1:0];
    z  = (yi == 0);
  endfunction

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    alu_if.A = 4'($urandom_range(0, MODV - 1));
    alu_if.B = 4'($urandom_range(0, MODV - 1));
    alu_if.mode = 3'($urandom_range(0, 7));
    @(posedge clk); #1;
    total++;
    if (alu_if.Y !== 4'b0000 || alu_if.carry_out !== 1'b0) begin
      bad++;
      $display("FAIL reset: Y=%b c=%b, want Y=0000 c=0", alu_if.Y, alu_if.carry_out);
    end
`ifdef NBIT_ALU_FLAGS_EN
    total++;
    if (alu_if.zero !== 1'b1 || alu_if.overflow !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags: zero=%b ovf=%b, want 1 0", alu_if.zero, alu_if.overflow);
    end
`endif
  endtask

  task automatic test_directed();
    vec_t v[13];
    v[0]  = '{4'b1111, 4'b0001, 3'b000, 4'b0000, 1'b1, 1'b1, 1'b0};
    v[1]  = '{4'b0011, 4'b0101, 3'b000, 4'b1000, 1'b0, 1'b0, 1'b1};
    v[2]  = '{4'b0101, 4'b0011, 3'b001, 4'b0010, 1'b0, 1'b0, 1'b0};
    v[3]  = '{4'b0001, 4'b0010, 3'b001, 4'b1111, 1'b1, 1'b0, 1'b0};
    v[4]  = '{4'b1111, 4'b1111, 3'b001, 4'b0000, 1'b0, 1'b1, 1'b0};
    v[5]  = '{4'b1100, 4'b1010, 3'b010, 4'b1000, 1'b0, 1'b0, 1'b0};
    v[6]  = '{4'b1100, 4'b1010, 3'b011, 4'b1110, 1'b0, 1'b0, 1'b0};
    v[7]  = '{4'b1111, 4'b1111, 3'b100, 4'b0000, 1'b0, 1'b1, 1'b0};
    v[8]  = '{4'b1010, 4'b0110, 3'b101, 4'b0101, 1'b0, 1'b0, 1'b0};
    v[9]  = '{4'b1111, 4'b1001, 3'b110, 4'b0000, 1'b1, 1'b1, 1'b0};
    v[10] = '{4'b0000, 4'b0011, 3'b111, 4'b1111, 1'b1, 1'b0, 1'b0};
    v[11] = '{4'b0010, 4'b1110, 3'b111, 4'b0001, 1'b0, 1'b0, 1'b0};
    v[12] = '{4'b0111, 4'b0000, 3'b110, 4'b1000, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      rst = 1'b0;
      alu_if.A = v[i].a; alu_if.B = v[i].b; alu_if.mode = v[i].m;
      @(posedge clk); #1;
      total++;
      if (alu_if.Y !== v[i].y || alu_if.carry_out !== v[i].c) begin
        bad++;
        $display("FAIL directed[%0d]: Y=%b c=%b, want Y=%b c=%b",
                 i, alu_if.Y, alu_if.carry_out, v[i].y, v[i].c);
      end
`ifdef NBIT_ALU_FLAGS_EN
      total++;
      if (alu_if.zero !== v[i].z || alu_if.overflow !== v[i].o) begin
        bad++;
        $display("FAIL directed_flags[%0d]: zero=%b ovf=%b, want %b %b",
                 i, alu_if.zero, alu_if.overflow, v[i].z, v[i].o);
      end
`endif
    end
  endtask

  task automatic test_random();
    logic [N-1:0] ey;
    logic ec, ez, eo;
    int a, b;
    logic [2:0] m;
    for (int i = 0; i < 200; i++) begin
      a = int'($urandom_range(0, MODV - 1));
      b = int'($urandom_range(0, MODV - 1));
      m = 3'($urandom_range(0, 7));
      @(negedge clk);
      rst = 1'b0;
      alu_if.A = a[N-1:0]; alu_if.B = b[N-1:0]; alu_if.mode = m;
      ref_op(a, b, m, ey, ec, ez, eo);
      @(posedge clk); #1;
      total++;
      if (alu_if.Y !== ey || alu_if.carry_out !== ec) begin
        bad++;
        $display("FAIL random: A=%0d B=%0d mode=%0d Y=%b c=%b, want Y=%b c=%b",
                 a, b, m, alu_if.Y, alu_if.carry_out, ey, ec);
      end
`ifdef NBIT_ALU_FLAGS_EN
      total++;
      if (alu_if.zero !== ez || alu_if.overflow !== eo) begin
        bad++;
        $display("FAIL random_flags: A=%0d B=%0d mode=%0d zero=%b ovf=%b, want %b %b",
                 a, b, m, alu_if.zero, alu_if.overflow, ez, eo);
      end
`endif
    end
  endtask

  // Every cycle a new mode; the old result must hold until the edge.
  task automatic test_back_to_back();
    logic [N-1:0] ey, prev_y;
    logic ec, ez, eo, prev_c;
    int a, b;
    prev_y = alu_if.Y;
    prev_c = alu_if.carry_out;
    for (int rep = 0; rep < 4; rep++) begin
      for (int k = 0; k < 8; k++) begin
        a = int'($urandom_range(0, MODV - 1));
        b = int'($urandom_range(0, MODV - 1));
        @(negedge clk);
        rst = 1'b0;
        alu_if.A = a[N-1:0]; alu_if.B = b[N-1:0]; alu_if.mode = 3'(k);
        ref_op(a, b, 3'(k), ey, ec, ez, eo);
        #1;
        total++;
        if (rep > 0 || k > 0) begin
          if (alu_if.Y !== prev_y || alu_if.carry_out !== prev_c) begin
            bad++;
            $display("FAIL b2b_hold: mode=%0d Y=%b c=%b, want held Y=%b c=%b",
                     k, alu_if.Y, alu_if.carry_out, prev_y, prev_c);
          end
        end else begin
          if (alu_if.Y === 4'bxxxx) begin
            bad++;
            $display("FAIL b2b_hold: Y=%b, want known value", alu_if.Y);
          end
        end
        @(posedge clk); #1;
        total++;
        if (alu_if.Y !== ey || alu_if.carry_out !== ec) begin
          bad++;
          $display("FAIL b2b: mode=%0d A=%0d B=%0d Y=%b c=%b, want Y=%b c=%b",
                   k, a, b, alu_if.Y, alu_if.carry_out, ey, ec);
        end
`ifdef NBIT_ALU_FLAGS_EN
        total++;
        if (alu_if.zero !== ez || alu_if.overflow !== eo) begin
          bad++;
          $display("FAIL b2b_flags: mode=%0d zero=%b ovf=%b, want %b %b",
                   k, alu_if.zero, alu_if.overflow, ez, eo);
        end
`endif
        prev_y = ey;
        prev_c = ec;
      end
    end
  endtask

  // ADD 1000+1000 with reset on one edge, then released with inputs held.
  task automatic test_reset_midstream();
    @(negedge clk);
    alu_if.A = 4'b1000; alu_if.B = 4'b1000; alu_if.mode = 3'b000;
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if (alu_if.Y !== 4'b0000 || alu_if.carry_out !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: Y=%b c=%b, want Y=0000 c=0", alu_if.Y, alu_if.carry_out);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if (alu_if.Y !== 4'b0000 || alu_if.carry_out !== 1'b1) begin
      bad++;
      $display("FAIL mid_release: Y=%b c=%b, want Y=0000 c=1", alu_if.Y, alu_if.carry_out);
    end
`ifdef NBIT_ALU_FLAGS_EN
    total++;
    if (alu_if.zero !== 1'b1 || alu_if.overflow !== 1'b1) begin
      bad++;
      $display("FAIL mid_release_flags: zero=%b ovf=%b, want 1 1", alu_if.zero, alu_if.overflow);
    end
`endif
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    alu_if.A = 4'b0000;
    alu_if.B = 4'b0000;
    alu_if.mode = 3'b000;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_midstream();
    test_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/nbit_alu.md
NBIT_ALU -- requirements
Module: nbit_alu

Interface
REQ-001 SHALL have parameter N, default 4, meaning operand and result width in bits (legal N >= 2).
REQ-002 SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port A  input  N  operand A, unsigned (two's complement for overflow flag).
REQ-005 SHALL have port B  input  N  operand B.
REQ-006 SHALL have port mode  input  3  operation select.
REQ-007 SHALL have port Y  output  N  registered result.
REQ-008 SHALL have port carry_out  output  1  registered carry/borrow.
REQ-009 SHALL, only when NBIT_ALU_FLAGS_EN is defined, have ports zero  output  1  (Y==0) and overflow  output  1  (signed overflow), both registered.

Function
REQ-010 SHALL sample A, B and mode on each rising clk edge and present the result on Y/carry_out after that edge: latency exactly 1 cycle, throughput 1 op/cycle, no handshake.
REQ-011 SHALL implement mode 000 ADD: Y = (A+B) mod 2^N; carry_out = bit N of the N+1-bit sum.
REQ-012 SHALL implement mode 001 SUB: Y = (A-B) mod 2^N; carry_out = 1 when A < B (borrow), else 0.
REQ-013 SHALL implement mode 010 AND: Y = A & B; carry_out = 0.
REQ-014 SHALL implement mode 011 OR: Y = A | B; carry_out = 0.
REQ-015 SHALL implement mode 100 XOR: Y = A ^ B; carry_out = 0.
REQ-016 SHALL implement mode 101 NOT: Y = ~A; B ignored; carry_out = 0.
REQ-017 SHALL implement mode 110 INC: Y = (A+1) mod 2^N; B ignored; carry_out = 1 only when A = all ones.
REQ-018 SHALL implement mode 111 DEC: Y = (A-1) mod 2^N; B ignored; carry_out = 1 (borrow) only when A = 0.
REQ-019 SHALL treat any X/unknown mode as no defined operation; all 8 encodings are defined, so no default path other than Y=0, carry_out=0 is required.
REQ-020 SHALL contain no combinational path from inputs to outputs.

Reset
REQ-021 SHALL, when rst is high at a rising clk edge, set Y=0, carry_out=0 (and zero=1, overflow=0 when flags compiled in), regardless of A, B, mode.
REQ-022 SHALL give rst priority over operation capture; reset asserted mid-stream discards the operation sampled on that edge.
REQ-023 SHALL resume normal capture on the first rising edge with rst low; first valid result appears one cycle after that edge.

Configuration
REQ-024 SHALL, with macro NBIT_ALU_FLAGS_EN defined, register zero = (next Y == 0) and overflow = signed two's-complement overflow for ADD, SUB, INC, DEC (0 for logic/NOT) with the same 1-cycle latency as Y.
REQ-025 SHALL, without NBIT_ALU_FLAGS_EN, omit zero and overflow ports and logic entirely; Y/carry_out behaviour unchanged.

Verification
REQ-026 SHALL verify ADD, N=4: A=1111,B=0001,mode=000 -> next cycle Y=0000, carry_out=1 (zero=1 if flags); A=0011,B=0101 -> Y=1000, carry_out=0 (overflow=1 if flags).
REQ-027 SHALL verify SUB: A=0101,B=0011 -> Y=0010, carry_out=0; A=0001,B=0010 -> Y=1111, carry_out=1; A=1111,B=1111 -> Y=0000, carry_out=0.
REQ-028 SHALL verify logic/NOT: AND 1100,1010 -> 1000; OR 1100,1010 -> 1110; XOR 1111,1111 -> 0000; NOT A=1010 -> 0101; carry_out=0 in all.
REQ-029 SHALL verify INC/DEC wrap: INC A=1111 -> Y=0000, carry_out=1; DEC A=0000 -> Y=1111, carry_out=1; DEC A=0010 -> Y=0001, carry_out=0.
REQ-030 SHALL verify reset: drive ADD 1000+1000, assert rst one edge -> Y=0000, carry_out=0 that edge; deassert -> Y=0000, carry_out=1 one cycle later.
REQ-031 SHALL verify latency: change mode every cycle across all 8 modes back-to-back -> each result appears exactly one edge after its inputs, none dropped.
